pc_sequencer: RTL

- Owns the fetch-stage PC register and decides each cycle which next-PC source is committed: sequential, branch/jump redirect, exception vector or exception return.
- Sits between the hazard/exception control and the instruction memory.
- Consumes the next-PC value computed in the decode stage as a redirect request.
- Holds redirects that arrive during a stall, so no branch target is lost.

---
 rtl/pc_sequencer_if.sv | 25 ++
 rtl/pc_sequencer.sv | 101 ++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Handshake bundle between hazard/exception control and the fetch-stage PC sequencer.
// The master is the controller side; the slave is pc_sequencer itself.
interface pc_sequencer_if;
  logic        istall;
  logic        iredir_valid;
  logic [31:0] iredir_target;
  logic        iexc_req;
  logic        ieret_req;
  logic [31:0] iepc;
  logic [31:0] oPC;
  logic        ofetch_valid;
  logic        oflush_if;
  logic        opending;
  logic        oadel_if;

  modport master (
    output istall, iredir_valid, iredir_target, iexc_req, ieret_req, iepc,
    input  oPC, ofetch_valid, oflush_if, opending, oadel_if
  );

  modport slave (
    input  istall, iredir_valid, iredir_target, iexc_req, ieret_req, iepc,
    output oPC, ofetch_valid, oflush_if, opending, oadel_if
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register: picks exception, eret, redirect, hold or sequential next-PC each cycle.
// Optional fetch-address bounds/alignment check is built when PC_BOUND_CHECK_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_6ffc
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]  state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pend, pend_next;
  logic        fetch_en;

  always_comb begin
    // NOTE: every variable gets its default before any branch, so no path can infer a latch.
    state_next = state;
    pc_next    = pc;
    pend_next  = pend;
    if (state == ST_BOOT) begin
      state_next = ST_RUN;
    end else if (bus.iexc_req) begin
      pc_next    = EXC_VECTOR;
      pend_next  = '0;
      state_next = ST_RUN;
    end else if (bus.ieret_req) begin
      pc_next    = bus.iepc;
      pend_next  = '0;
      state_next = ST_RUN;
    end else if (state == ST_PEND) begin
      // A fresh redirect during the release cycle supersedes the stored one.
      if (bus.istall) begin
        if (bus.iredir_valid) pend_next = bus.iredir_target;
      end else begin
        pc_next    = bus.iredir_valid ? bus.iredir_target : pend;
        pend_next  = '0;
        state_next = ST_RUN;
      end
    end else if (bus.iredir_valid) begin
      if (bus.istall) begin
        pend_next  = bus.iredir_target;
        state_next = ST_PEND;
      end else begin
        pc_next = bus.iredir_target;
      end
    end else if (!bus.istall) begin
      pc_next = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      pend     <= '0;
      fetch_en <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state    <= state_next;
      pc       <= pc_next;
      pend     <= pend_next;
      fetch_en <= 1'b1;
    end
  end

  // Flush only when an exception or eret is actually accepted; BOOT ignores requests.
  assign bus.oflush_if = (state != ST_BOOT) && (bus.iexc_req || bus.ieret_req);
  assign bus.oPC       = pc;
  assign bus.opending  = (state == ST_PEND);

`ifdef PC_BOUND_CHECK_EN
  logic adel;

  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IMEM_BASE) || (addr > IMEM_LIMIT);
  endfunction

  // Evaluated on every load; a held PC re-evaluates to the same result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) adel <= 1'b0;
    else       adel <= addr_bad(pc_next);
  end

  assign bus.oadel_if     = adel;
  assign bus.ofetch_valid = fetch_en & ~adel;
`else
  logic unused_bounds;
  assign unused_bounds    = ^{IMEM_BASE, IMEM_LIMIT};
  assign bus.oadel_if     = 1'b0;
  assign bus.ofetch_valid = fetch_en;
`endif

endmodule
